// File: rtl/instr_encoder.sv
// Encodes ADD/SUB/NOP requests into 16-bit words and issues them through a DEPTH-entry FIFO.
// Optional feature: define INSTR_ENC_RDZERO_NOP_EN to encode ADD/SUB with rd=0 as a NOP.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] instr,
  output logic        illegal,
  output logic [7:0]  issued_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [15:0]  NOP_WORD   = 16'hF000;

  typedef enum logic [1:0] {
    KIND_ADD = 2'd0,
    KIND_SUB = 2'd1,
    KIND_NOP = 2'd2,
    KIND_ILL = 2'd3
  } kind_e;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          illegal_q, illegal_d;
  logic [7:0]    issued_q, issued_d;

  kind_e       kind;
  logic [15:0] enc_word;
  logic        accept;
  logic        push;
  logic        pop;

  assign kind = kind_e'(in_kind);

  always_comb begin
    enc_word = NOP_WORD;
    case (kind)
      KIND_ADD: enc_word = {4'b0000, rd, rs1, rs2};
      KIND_SUB: enc_word = {4'b0001, rd, rs1, rs2};
      default:  enc_word = NOP_WORD;
    endcase
`ifdef INSTR_ENC_RDZERO_NOP_EN
    if ((kind == KIND_ADD || kind == KIND_SUB) && rd == 4'd0) begin
      enc_word = NOP_WORD;
    end
`endif
  end

  // Illegal kinds complete the handshake but never occupy a queue slot.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (kind != KIND_ILL);
  assign pop       = out_valid && out_ready;

  assign instr        = out_valid ? mem_q[rd_ptr_q] : NOP_WORD;
  assign illegal      = illegal_q;
  assign issued_count = issued_q;

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    issued_d  = pop  ? issued_q + 8'd1   : issued_q;
    illegal_d = illegal_q | (accept && kind == KIND_ILL);
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP_WORD;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      issued_q  <= 8'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= enc_word;
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      issued_q  <= issued_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a scoreboard queue models the FIFO contents and flags.
// Honours INSTR_ENC_RDZERO_NOP_EN when computing expected words.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instr;
  logic        illegal;
  logic [7:0]  issued_count;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [15:0] sb[$];
  logic        illegalModel = 1'b0;
  logic [7:0]  issuedModel  = 8'd0;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_kind     (in_kind),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instr       (instr),
    .illegal     (illegal),
    .issued_count(issued_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] expectWord(input logic [1:0] k, input logic [3:0] d,
                                             input logic [3:0] a, input logic [3:0] b);
    logic [15:0] w;
    case (k)
      2'd0:    w = {4'h0, d, a, b};
      2'd1:    w = {4'h1, d, a, b};
      default: w = 16'hF000;
    endcase
`ifdef INSTR_ENC_RDZERO_NOP_EN
    if (k < 2'd2 && d == 4'd0) w = 16'hF000;
`endif
    return w;
  endfunction

  // Checks outputs against the model mid-cycle, then advances the model for the coming edge.
  always @(negedge clk) begin
    logic expReady;
    if (!rst_n) begin
      sb.delete();
      illegalModel = 1'b0;
      issuedModel  = 8'd0;
    end
    checkOutput("outValid", {15'd0, out_valid}, {15'd0, sb.size() != 0});
    checkOutput("inReady", {15'd0, in_ready}, {15'd0, sb.size() < DEPTH});
    checkOutput("illegal", {15'd0, illegal}, {15'd0, illegalModel});
    checkOutput("issuedCount", {8'd0, issued_count}, {8'd0, issuedModel});
    if (sb.size() != 0) checkOutput("head", instr, sb[0]);
    else                checkOutput("emptyInstr", instr, 16'hF000);
    if (rst_n) begin
      expReady = (sb.size() < DEPTH);
      if (sb.size() != 0 && out_ready) begin
        void'(sb.pop_front());
        issuedModel = issuedModel + 8'd1;
      end
      if (in_valid && expReady) begin
        if (in_kind == 2'd3) illegalModel = 1'b1;
        else                 sb.push_back(expectWord(in_kind, rd, rs1, rs2));
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] k, input logic [3:0] d,
                               input logic [3:0] a, input logic [3:0] b);
    int   guard = 0;
    logic ok;
    in_valid = 1'b1;
    in_kind  = k;
    rd       = d;
    rs1      = a;
    rs2      = b;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      guard++;
    end while (!ok && guard < 200);
    if (!ok) checkOutput("acceptTimeout", 16'd0, 16'd1);
    #1 in_valid = 1'b0;
  endtask

  task automatic drainQueue();
    int guard = 0;
    out_ready = 1'b1;
    @(posedge clk);
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() != 0) checkOutput("drainTimeout", 16'd0, 16'd1);
    #1;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_kind   = 2'd0;
    rd        = 4'd0;
    rs1       = 4'd0;
    rs2       = 4'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single ADD straight through
    out_ready = 1'b1;
    applyStimulus(2'd0, 4'd3, 4'd1, 4'd2);
    @(negedge clk);
    checkOutput("addWord", instr, 16'h0312);
    checkOutput("addValid", {15'd0, out_valid}, 16'd1);
    @(negedge clk);
    checkOutput("addIssued", {8'd0, issued_count}, 16'd1);
    @(posedge clk);
    #1;

    // Fill to full with a fifth word held off
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(2'(i % 2), 4'(i + 1), 4'(i), 4'(2 * i));
    @(negedge clk);
    checkOutput("fullReady", {15'd0, in_ready}, 16'd0);
    @(posedge clk);
    #1;
    fork
      applyStimulus(2'd1, 4'd5, 4'd6, 4'd7);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drainQueue();

    // One-entry occupancy with simultaneous push and pop
    out_ready = 1'b0;
    applyStimulus(2'd0, 4'd9, 4'd8, 4'd7);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(2'(i % 3), 4'(i + 1), 4'(i + 2), 4'(i + 3));
    drainQueue();

    // Illegal kind is swallowed and sticks
    out_ready = 1'b0;
    applyStimulus(2'd3, 4'd7, 4'd7, 4'd7);
    applyStimulus(2'd1, 4'd1, 4'd2, 4'd3);
    @(negedge clk);
    checkOutput("subWord", instr, 16'h1123);
    checkOutput("illegalSet", {15'd0, illegal}, 16'd1);
    @(posedge clk);
    #1;
    drainQueue();
    @(negedge clk);
    checkOutput("illegalSticky", {15'd0, illegal}, 16'd1);
    @(posedge clk);
    #1;

    // 257 issues, then reset with two entries queued
    pulseReset();
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++)
      applyStimulus(2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    drainQueue();
    out_ready = 1'b0;
    applyStimulus(2'd0, 4'd2, 4'd2, 4'd2);
    applyStimulus(2'd1, 4'd4, 4'd4, 4'd4);
    @(negedge clk);
    checkOutput("wrapCount", {8'd0, issued_count}, 16'd1);
    checkOutput("twoQueued", {15'd0, out_valid}, 16'd1);
    @(posedge clk);
    #1;
    pulseReset();
    @(negedge clk);
    checkOutput("rstValid", {15'd0, out_valid}, 16'd0);
    checkOutput("rstCount", {8'd0, issued_count}, 16'd0);
    checkOutput("rstInstr", instr, 16'hF000);
    @(posedge clk);
    #1;

    // rd=0 handling, also the first word after reset
    applyStimulus(2'd0, 4'd0, 4'd4, 4'd5);
    @(negedge clk);
`ifdef INSTR_ENC_RDZERO_NOP_EN
    checkOutput("rdZero", instr, 16'hF000);
`else
    checkOutput("rdZero", instr, 16'h0045);
`endif
    @(posedge clk);
    #1;
    drainQueue();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
